// File: rtl/seq_wr_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_wr_if
// Description : Request/beat bundle between writeback control and the
//               sequencing write-select decoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_wr_if #(
    parameter int ADDR_W = 5,
    parameter int LEN_W  = 4
);
    localparam int NUM_OUT = 2 ** ADDR_W;

    logic                 req_valid;
    logic                 req_ready;
    logic [ADDR_W-1:0]    req_addr;
    logic [LEN_W-1:0]     req_len;
    logic [NUM_OUT-1:0]   out_onehot;
    logic                 out_valid;
    logic [ADDR_W-1:0]    out_addr;
    logic                 done;
    logic                 busy;

    // Requester side: issues requests, observes the beat stream
    modport master (
        output req_valid, req_addr, req_len,
        input  req_ready, out_onehot, out_valid, out_addr, done, busy
    );

    // Decoder side: accepts requests, produces the beat stream
    modport slave (
        input  req_valid, req_addr, req_len,
        output req_ready, out_onehot, out_valid, out_addr, done, busy
    );
endinterface
`default_nettype wire

// File: rtl/seq_wr_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seq_wr_decoder
// Description : Registered N-to-2^N one-hot write-select decoder with enable
//               and a burst mode emitting one beat per cycle over
//               consecutive (wrapping) addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_wr_decoder #(
    parameter int ADDR_W   = 5,
    parameter int LEN_W    = 4,
    parameter int MASK_TOP = 1
) (
    input  wire logic clk,
    input  wire logic reset_n,
    input  wire logic en,
    seq_wr_if.slave   bus
);
    localparam int                NUM_OUT  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(NUM_OUT - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]          state_q,  state_d;
    logic [ADDR_W-1:0]   cur_q,    cur_d;
    logic [LEN_W-1:0]    rem_q,    rem_d;
    logic [NUM_OUT-1:0]  onehot_q, onehot_d;
    logic                valid_q,  valid_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic                done_q,   done_d;

    logic                w_accept;
    logic                w_step;
    logic [ADDR_W-1:0]   w_beat_addr;

    // A new request is only taken while idle and enabled; RUN advances only when enabled
    assign w_accept    = (state_q == ST_IDLE) && en && bus.req_valid;
    assign w_step      = (state_q == ST_RUN) && en;
    assign w_beat_addr = w_accept ? bus.req_addr : cur_q;

    // State and beat registers, cleared asynchronously so an abandoned burst never resumes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cur_q    <= '0;
            rem_q    <= '0;
            onehot_q <= '0;
            valid_q  <= 1'b0;
            addr_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            rem_q    <= rem_d;
            onehot_q <= onehot_d;
            valid_q  <= valid_d;
            addr_q   <= addr_d;
            done_q   <= done_d;
        end
    end

    // Next state: single-beat requests stay IDLE so they can issue every cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (w_accept && (bus.req_len != '0)) state_d = ST_RUN;
            ST_RUN:  if (w_step && (rem_q == LEN_W'(1)))  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Beat datapath: load a beat on accept or step, otherwise blank the outputs
    always_comb begin
        onehot_d = '0;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        addr_d   = addr_q;
        cur_d    = cur_q;
        rem_d    = rem_q;
        if (w_accept || w_step) begin
            valid_d = 1'b1;
            addr_d  = w_beat_addr;
            cur_d   = w_beat_addr + ADDR_W'(1);
            // The top address is the hard-wired zero register when masking is on
            if (!((MASK_TOP != 0) && (w_beat_addr == TOP_ADDR))) begin
                onehot_d[w_beat_addr] = 1'b1;
            end
            if (w_accept) begin
                rem_d  = bus.req_len;
                done_d = (bus.req_len == '0);
            end else begin
                rem_d  = rem_q - LEN_W'(1);
                done_d = (rem_q == LEN_W'(1));
            end
        end
    end

    // Outputs: ready is combinational from state so it never waits on req_valid
    always_comb begin
        bus.req_ready  = (state_q == ST_IDLE) && en;
        bus.busy       = (state_q == ST_RUN);
        bus.out_onehot = onehot_q;
        bus.out_valid  = valid_q;
        bus.out_addr   = addr_q;
        bus.done       = done_q;
    end
endmodule
`default_nettype wire

// File: tb/tb_seq_wr_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_wr_decoder
// Description : Directed self-checking bench for seq_wr_decoder. A masked
//               (MASK_TOP=1) and an unmasked (MASK_TOP=0) instance receive
//               identical stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_wr_decoder;
    localparam int ADDR_W = 5;
    localparam int LEN_W  = 4;

    // onehot(32) valid(1) addr(5) done(1) busy(1) ready(1)
    typedef logic [40:0] snap_t;

    logic clk;
    logic reset_n;
    logic en;
    int   checks;
    int   failures;

    seq_wr_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) ifm ();
    seq_wr_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) ifu ();

    assign ifu.req_valid = ifm.req_valid;
    assign ifu.req_addr  = ifm.req_addr;
    assign ifu.req_len   = ifm.req_len;

    seq_wr_decoder #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .MASK_TOP(1)) dut_m (
        .clk(clk), .reset_n(reset_n), .en(en), .bus(ifm.slave)
    );
    seq_wr_decoder #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .MASK_TOP(0)) dut_u (
        .clk(clk), .reset_n(reset_n), .en(en), .bus(ifu.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic snap_t mk(logic [31:0] oh, logic v, logic [4:0] a,
                                 logic d, logic b, logic r);
        return {oh, v, a, d, b, r};
    endfunction

    function automatic snap_t obs_m();
        return {ifm.out_onehot, ifm.out_valid, ifm.out_addr, ifm.done, ifm.busy, ifm.req_ready};
    endfunction

    function automatic logic [31:0] bit_of(int a);
        logic [31:0] one;
        one = 32'd1;
        return one << a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic v, logic [4:0] a, logic [3:0] l);
        ifm.req_valid = v;
        ifm.req_addr  = a;
        ifm.req_len   = l;
    endtask

    task automatic test_reset();
        snap_t e;
        drive(1'b0, 5'd0, 4'd0);
        en      = 1'b1;
        reset_n = 1'b0;
        #12;
        checks++;
        if (ifm.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready_during_reset actual=%b required=1", ifm.req_ready);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        tick();
        e = mk(32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs_m() !== e) begin
            failures++;
            $display("FAIL reset_idle actual=%h required=%h", obs_m(), e);
        end
    endtask

    task automatic test_singles();
        snap_t e;
        for (int i = 3; i <= 5; i++) begin
            drive(1'b1, 5'(i), 4'd0);
            tick();
            e = mk(bit_of(i), 1'b1, 5'(i), 1'b1, 1'b0, 1'b1);
            checks++;
            if (obs_m() !== e) begin
                failures++;
                $display("FAIL single_addr%0d actual=%h required=%h", i, obs_m(), e);
            end
        end
        drive(1'b0, 5'd9, 4'd0);
        tick();
        e = mk(32'd0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs_m() !== e) begin
            failures++;
            $display("FAIL single_idle_hold actual=%h required=%h", obs_m(), e);
        end
    endtask

    task automatic test_burst_wrap_mask();
        snap_t       e;
        logic [4:0]  ea [4];
        logic [31:0] eo [4];
        logic        ed [4];
        logic        eb [4];
        ea = '{5'd29, 5'd30, 5'd31, 5'd0};
        eo = '{32'h2000_0000, 32'h4000_0000, 32'h0, 32'h1};
        ed = '{1'b0, 1'b0, 1'b0, 1'b1};
        eb = '{1'b1, 1'b1, 1'b1, 1'b0};
        drive(1'b1, 5'd29, 4'd3);
        for (int j = 0; j < 4; j++) begin
            tick();
            // later request fields must be ignored while the burst runs
            drive(1'b0, 5'd7, 4'd5);
            e = mk(eo[j], 1'b1, ea[j], ed[j], eb[j], ~eb[j]);
            checks++;
            if (obs_m() !== e) begin
                failures++;
                $display("FAIL burst_beat%0d actual=%h required=%h", j, obs_m(), e);
            end
            if (j == 2) begin
                checks++;
                if (ifu.out_onehot !== 32'h8000_0000) begin
                    failures++;
                    $display("FAIL burst_unmasked_top actual=%h required=80000000", ifu.out_onehot);
                end
            end
        end
        tick();
        e = mk(32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs_m() !== e) begin
            failures++;
            $display("FAIL burst_after actual=%h required=%h", obs_m(), e);
        end
    endtask

    task automatic test_stall();
        snap_t e;
        drive(1'b1, 5'd8, 4'd2);
        tick();
        drive(1'b0, 5'd0, 4'd0);
        e = mk(bit_of(8), 1'b1, 5'd8, 1'b0, 1'b1, 1'b0);
        checks++;
        if (obs_m() !== e) begin
            failures++;
            $display("FAIL stall_beat8 actual=%h required=%h", obs_m(), e);
        end
        en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            e = mk(32'd0, 1'b0, 5'd8, 1'b0, 1'b1, 1'b0);
            checks++;
            if (obs_m() !== e) begin
                failures++;
                $display("FAIL stall_hold%0d actual=%h required=%h", k, obs_m(), e);
            end
        end
        en = 1'b1;
        tick();
        e = mk(bit_of(9), 1'b1, 5'd9, 1'b0, 1'b1, 1'b0);
        checks++;
        if (obs_m() !== e) begin
            failures++;
            $display("FAIL stall_beat9 actual=%h required=%h", obs_m(), e);
        end
        tick();
        e = mk(bit_of(10), 1'b1, 5'd10, 1'b1, 1'b0, 1'b1);
        checks++;
        if (obs_m() !== e) begin
            failures++;
            $display("FAIL stall_beat10 actual=%h required=%h", obs_m(), e);
        end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        snap_t e;
        drive(1'b1, 5'd0, 4'd7);
        tick();
        drive(1'b0, 5'd0, 4'd0);
        tick();
        tick();
        e = mk(bit_of(2), 1'b1, 5'd2, 1'b0, 1'b1, 1'b0);
        checks++;
        if (obs_m() !== e) begin
            failures++;
            $display("FAIL midrst_beat2 actual=%h required=%h", obs_m(), e);
        end
        reset_n = 1'b0;
        #1;
        e = mk(32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (obs_m() !== e) begin
            failures++;
            $display("FAIL midrst_async_clear actual=%h required=%h", obs_m(), e);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        tick();
        checks++;
        if (obs_m() !== e) begin
            failures++;
            $display("FAIL midrst_no_resume actual=%h required=%h", obs_m(), e);
        end
        drive(1'b1, 5'd6, 4'd1);
        tick();
        drive(1'b0, 5'd0, 4'd0);
        e = mk(bit_of(6), 1'b1, 5'd6, 1'b0, 1'b1, 1'b0);
        checks++;
        if (obs_m() !== e) begin
            failures++;
            $display("FAIL midrst_new_beat6 actual=%h required=%h", obs_m(), e);
        end
        tick();
        e = mk(bit_of(7), 1'b1, 5'd7, 1'b1, 1'b0, 1'b1);
        checks++;
        if (obs_m() !== e) begin
            failures++;
            $display("FAIL midrst_new_beat7 actual=%h required=%h", obs_m(), e);
        end
        tick();
    endtask

    task automatic test_exhaustive();
        snap_t       e;
        logic [31:0] exp_m;
        for (int a = 0; a < 32; a++) begin
            drive(1'b1, 5'(a), 4'd0);
            tick();
            exp_m = (a == 31) ? 32'd0 : bit_of(a);
            e = mk(exp_m, 1'b1, 5'(a), 1'b1, 1'b0, 1'b1);
            checks++;
            if (obs_m() !== e) begin
                failures++;
                $display("FAIL exh_masked_addr%0d actual=%h required=%h", a, obs_m(), e);
            end
            checks++;
            if ({ifu.out_onehot, ifu.out_valid, ifu.out_addr} !== {bit_of(a), 1'b1, 5'(a)}) begin
                failures++;
                $display("FAIL exh_unmasked_addr%0d actual=%h/%b/%0d required=%h/1/%0d",
                         a, ifu.out_onehot, ifu.out_valid, ifu.out_addr, bit_of(a), a);
            end
        end
        drive(1'b0, 5'd0, 4'd0);
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_singles();
        test_burst_wrap_mask();
        test_stall();
        test_reset_mid_burst();
        test_exhaustive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
